mii_rx_frame: RTL and testbench
===============================

# mii_rx_frame

MII receive front-end for one switch port, sitting between the PHY's MII receive pins and the port's ingress frame logic. It strips preamble and SFD and assembles low-nibble-first pairs into bytes. It checks FCS, alignment, length and RX_ER, and emits a byte stream with start/end markers plus a per-frame status strobe. Four instances, one per port, feed the switch core.

## Interface
- `MIN_LEN`, 64, minimum legal frame bytes, DA through FCS.
- `MAX_LEN`, 1518, maximum legal frame bytes, DA through FCS.
- `clk`  in  1  MII_RX_CLK of the port. One clock only.
- `rstn`  in  1  reset, asynchronous, active-low.
- `mii_rxd`  in  4  receive nibble.
- `mii_rx_dv`  in  1  receive data valid.
- `mii_rx_er`  in  1  receive error.
- `data_out`  out  8  assembled byte.
- `data_valid`  out  1  `data_out` valid; one-cycle pulse per byte.
- `sof`  out  1  coincident with the first `data_valid` of a frame.
- `eof`  out  1  one-cycle end-of-frame pulse. Never coincident with `data_valid`.
- `frame_len`  out  11  byte count from DA through FCS. Saturates at 2047. Valid with `eof`.
- `frame_ok`  out  1  no error flag set. Valid with `eof`.
- `crc_err`, `align_err`, `len_err`, `phy_err`  out  1 each  error flags. Valid with `eof`.

## Operation
- FSM states: IDLE, PREAMBLE, DATA, DROP.
- **IDLE**
  - `mii_rx_dv`=1 and nibble 0x5 → PREAMBLE.
  - `mii_rx_dv`=1 and nibble 0xD → DATA.
  - `mii_rx_dv`=1 and any other nibble → DROP.
- **PREAMBLE**
  - 0x5 → stay.
  - 0xD → DATA.
  - Other nibble → DROP.
  - `mii_rx_dv` falls → IDLE. No `eof`.
- **DATA**
  - Nibble phase toggles each cycle. Even phase latches the low nibble.
  - Odd phase forms byte {hi, lo}. The byte updates the CRC and increments the length counter.
  - `mii_rx_er`=1 while in DATA sets sticky `phy_err`.
  - `mii_rx_dv` falls → IDLE. `eof` pulses the next cycle with status.
- **DROP**: ignore input until `mii_rx_dv`=0, then → IDLE. No outputs.
- **CRC**
  - Reflected CRC-32, poly 0xEDB88320, init 0xFFFFFFFF, bits LSB-first per byte.
  - Computed over DA through FCS.
  - Frame passes if the register equals residue 0xDEBB20E3 at the end of frame.
- **Errors**
  - `align_err`: `mii_rx_dv` fell with an odd nibble count, i.e. a dangling low nibble. The dangling nibble is discarded.
  - `len_err`: `frame_len` < MIN_LEN or > MAX_LEN.
  - `frame_ok` = no flag set.
- `mii_rx_dv` re-asserting the cycle after the fall is accepted: IDLE handles it while `eof` issues.
- Asserting `rstn` mid-frame aborts the frame silently. No `eof`.

## Timing
- Reset value of all outputs: 0. FSM resets to IDLE; counters and phase reset to 0; CRC register resets to 0xFFFFFFFF.
- Byte latency: `data_valid` rises the cycle after the high-nibble edge. The byte rate is one per two clocks.
- `eof` occurs exactly one cycle after the first cycle with `mii_rx_dv`=0. Status outputs hold until the next `eof`.
- CRC check uses the register after the final FCS byte, taken the same cycle `eof` is registered.

## Configuration
- `MII_RX_FCS_STRIP_EN` defined:
  - A 4-byte delay line holds each byte; a byte is emitted only when a fifth byte arrives behind it.
  - The 4 FCS bytes are never output. Bytes emerge 8 clocks later than without the macro.
  - Frames of 4 bytes or fewer produce no `sof` or `data_valid`, but still produce `eof` with status.
- Undefined: every byte including FCS is output. No delay line.
- `frame_len` always includes FCS.

## Structure
- Package `mii_rx_pkg` holds:
  - the FSM state enum;
  - `CRC32_POLY`, `CRC32_INIT` and `CRC32_RESIDUE`;
  - the default `MIN_LEN`/`MAX_LEN` constants;
  - the preamble/SFD nibble constants 0x5/0xD.
- Sub-module `crc32_byte_chk` is natural.
  - Inputs: `clk`, `rstn`, init strobe, byte, byte-valid.
  - Outputs: the CRC register and a `residue_ok` compare.

## Test plan
- 15×0x5, 0xD, then a 64-byte frame (DA ffffffffffff, SA e0e1e2e3e4e5, type 0806, random payload, correct FCS):
  - first byte 0xFF with `sof`;
  - 64 bytes output, or 60 with the macro;
  - `eof` with `frame_len`=64 and `frame_ok`=1.
- Same frame with inverted FCS → `crc_err`=1, `frame_ok`=0. Data still forwarded.
- Preamble containing nibble 0x3 → no `sof`, no `data_valid`, no `eof`.
- Frame with one extra nibble after FCS → `align_err`=1, `frame_len`=64. Nibble discarded.
- 100-byte frame with `mii_rx_er` pulsed at byte 20 → `phy_err`=1. Separately, a 40-byte good-CRC frame → `len_err`=1.
- `rstn` low mid-frame, then two back-to-back good frames separated by one idle cycle:
  - all outputs 0 during reset, no `eof` for the aborted frame;
  - two clean `eof`s, each with `frame_ok`=1.

Source files
------------

// File: rtl/mii_rx_pkg.sv
// Shared types and constants for the MII receive front-end: FSM states,
// CRC-32 parameters, default length limits and preamble/SFD nibbles.
package mii_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_e;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

  localparam int DEF_MIN_LEN = 64;
  localparam int DEF_MAX_LEN = 1518;

  localparam logic [3:0] NIB_PREAMBLE = 4'h5;
  localparam logic [3:0] NIB_SFD      = 4'hD;

  localparam logic [10:0] LEN_SAT = 11'd2047;

  // Reflected CRC-32 advanced by one byte, LSB first.
  function automatic logic [31:0] crc32_update(input logic [31:0] crc_in,
                                               input logic [7:0]  byte_in);
    logic [31:0] c;
    c = crc_in ^ {24'h00_0000, byte_in};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = {1'b0, c[31:1]} ^ CRC32_POLY;
      end else begin
        c = {1'b0, c[31:1]};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/mii_rx_frame_crc.sv
// Byte-wide CRC-32 accumulator with residue compare; restarted by init_i at
// the start of each frame.
module crc32_byte_chk
  import mii_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        init_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_vld_i,
  output logic [31:0] crc_o,
  output logic        residue_ok_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // Next CRC value: restart, advance by one byte, or hold.
  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = CRC32_INIT;
    end else if (byte_vld_i) begin
      crc_d = crc32_update(crc_q, byte_i);
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crc_q <= CRC32_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o        = crc_q;
  assign residue_ok_o = (crc_q == CRC32_RESIDUE);

endmodule

// File: rtl/mii_rx_frame.sv
// MII receive front-end: preamble/SFD strip, nibble-to-byte assembly, FCS,
// alignment, length and RX_ER checks. Define MII_RX_FCS_STRIP_EN to hold
// back and drop the four FCS bytes from the output stream.
module mii_rx_frame
  import mii_rx_pkg::*;
#(
  parameter int MIN_LEN = DEF_MIN_LEN,
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  mii_rxd,
  input  logic        mii_rx_dv,
  input  logic        mii_rx_er,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        sof,
  output logic        eof,
  output logic [10:0] frame_len,
  output logic        frame_ok,
  output logic        crc_err,
  output logic        align_err,
  output logic        len_err,
  output logic        phy_err
);

`ifdef MII_RX_FCS_STRIP_EN
  localparam logic [10:0] EMIT_START = 11'd4;
`else
  localparam logic [10:0] EMIT_START = 11'd0;
`endif

  rx_state_e   state_q, state_d;
  logic        phase_q, phase_d;
  logic [3:0]  lo_q, lo_d;
  logic [10:0] len_q, len_d;
  logic        phy_q, phy_d;

  logic [7:0]  data_out_q, data_out_d;
  logic        data_valid_q, data_valid_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic [10:0] frame_len_q, frame_len_d;
  logic        frame_ok_q, frame_ok_d;
  logic        crc_err_q, crc_err_d;
  logic        align_err_q, align_err_d;
  logic        len_err_q, len_err_d;
  logic        phy_err_q, phy_err_d;

`ifdef MII_RX_FCS_STRIP_EN
  logic [3:0][7:0] dline_q, dline_d;
`endif

  logic        start_s;
  logic        byte_vld_s;
  logic [7:0]  byte_s;
  logic [31:0] crc_s;
  logic        residue_ok_s;
  logic        crc_bad_s;
  logic        len_bad_s;

  assign byte_s = {mii_rxd, lo_q};

  crc32_byte_chk u_crc (
    .clk          (clk),
    .rstn         (rstn),
    .init_i       (start_s),
    .byte_i       (byte_s),
    .byte_vld_i   (byte_vld_s),
    .crc_o        (crc_s),
    .residue_ok_o (residue_ok_s)
  );

  // Dual compare: flag the CRC if either the checker or the raw register disagrees.
  assign crc_bad_s = ~residue_ok_s | (crc_s != CRC32_RESIDUE);
  assign len_bad_s = (len_q < 11'(MIN_LEN)) || (len_q > 11'(MAX_LEN));

  // Receive FSM, byte assembly and status capture.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    lo_d         = lo_q;
    len_d        = len_q;
    phy_d        = phy_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    sof_d        = 1'b0;
    eof_d        = 1'b0;
    frame_len_d  = frame_len_q;
    frame_ok_d   = frame_ok_q;
    crc_err_d    = crc_err_q;
    align_err_d  = align_err_q;
    len_err_d    = len_err_q;
    phy_err_d    = phy_err_q;
    start_s      = 1'b0;
    byte_vld_s   = 1'b0;
`ifdef MII_RX_FCS_STRIP_EN
    dline_d      = dline_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!mii_rx_dv) begin
          state_d = ST_IDLE;
        end else if (mii_rxd == NIB_PREAMBLE) begin
          state_d = ST_PREAMBLE;
        end else if (mii_rxd == NIB_SFD) begin
          state_d = ST_DATA;
          start_s = 1'b1;
        end else begin
          state_d = ST_DROP;
        end
      end
      ST_PREAMBLE: begin
        if (!mii_rx_dv) begin
          state_d = ST_IDLE;
        end else if (mii_rxd == NIB_PREAMBLE) begin
          state_d = ST_PREAMBLE;
        end else if (mii_rxd == NIB_SFD) begin
          state_d = ST_DATA;
          start_s = 1'b1;
        end else begin
          state_d = ST_DROP;
        end
      end
      ST_DATA: begin
        if (!mii_rx_dv) begin
          // End of frame: the CRC and length already cover the last full byte.
          state_d     = ST_IDLE;
          eof_d       = 1'b1;
          frame_len_d = len_q;
          crc_err_d   = crc_bad_s;
          align_err_d = phase_q;
          len_err_d   = len_bad_s;
          phy_err_d   = phy_q;
          frame_ok_d  = ~(crc_bad_s | phase_q | len_bad_s | phy_q);
        end else begin
          state_d = ST_DATA;
          phy_d   = phy_q | mii_rx_er;
          if (!phase_q) begin
            lo_d    = mii_rxd;
            phase_d = 1'b1;
          end else begin
            phase_d    = 1'b0;
            byte_vld_s = 1'b1;
            len_d      = (len_q == LEN_SAT) ? len_q : len_q + 11'd1;
`ifdef MII_RX_FCS_STRIP_EN
            dline_d = {dline_q[2:0], byte_s};
            if (len_q >= EMIT_START) begin
              data_out_d   = dline_q[3];
              data_valid_d = 1'b1;
              sof_d        = (len_q == EMIT_START);
            end else begin
              data_valid_d = 1'b0;
            end
`else
            data_out_d   = byte_s;
            data_valid_d = 1'b1;
            sof_d        = (len_q == EMIT_START);
`endif
          end
        end
      end
      ST_DROP: begin
        if (!mii_rx_dv) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start_s) begin
      phase_d = 1'b0;
      lo_d    = 4'h0;
      len_d   = 11'd0;
      phy_d   = 1'b0;
    end else begin
      phase_d = phase_d;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      phase_q      <= 1'b0;
      lo_q         <= 4'h0;
      len_q        <= 11'd0;
      phy_q        <= 1'b0;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      frame_len_q  <= 11'd0;
      frame_ok_q   <= 1'b0;
      crc_err_q    <= 1'b0;
      align_err_q  <= 1'b0;
      len_err_q    <= 1'b0;
      phy_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      lo_q         <= lo_d;
      len_q        <= len_d;
      phy_q        <= phy_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      frame_len_q  <= frame_len_d;
      frame_ok_q   <= frame_ok_d;
      crc_err_q    <= crc_err_d;
      align_err_q  <= align_err_d;
      len_err_q    <= len_err_d;
      phy_err_q    <= phy_err_d;
    end
  end

`ifdef MII_RX_FCS_STRIP_EN
  // FCS hold-back delay line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dline_q <= 32'h0000_0000;
    end else begin
      dline_q <= dline_d;
    end
  end
`endif

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign sof        = sof_q;
  assign eof        = eof_q;
  assign frame_len  = frame_len_q;
  assign frame_ok   = frame_ok_q;
  assign crc_err    = crc_err_q;
  assign align_err  = align_err_q;
  assign len_err    = len_err_q;
  assign phy_err    = phy_err_q;

endmodule

// File: tb/tb_mii_rx_frame.sv
// Directed self-checking bench for mii_rx_frame: good/bad FCS, bad preamble,
// alignment, PHY error, short frame, reset abort and back-to-back frames.
module tb_mii_rx_frame;

`ifdef MII_RX_FCS_STRIP_EN
  localparam int STRIP = 4;
`else
  localparam int STRIP = 0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  mii_rxd = 4'h0;
  logic        mii_rx_dv = 1'b0;
  logic        mii_rx_er = 1'b0;
  logic [7:0]  data_out;
  logic        data_valid, sof, eof;
  logic [10:0] frame_len;
  logic        frame_ok, crc_err, align_err, len_err, phy_err;

  mii_rx_frame dut (
    .clk(clk), .rstn(rstn), .mii_rxd(mii_rxd), .mii_rx_dv(mii_rx_dv),
    .mii_rx_er(mii_rx_er), .data_out(data_out), .data_valid(data_valid),
    .sof(sof), .eof(eof), .frame_len(frame_len), .frame_ok(frame_ok),
    .crc_err(crc_err), .align_err(align_err), .len_err(len_err),
    .phy_err(phy_err)
  );

  always #5 clk = ~clk;

  wire [26:0] all_outs = {data_out, data_valid, sof, eof, frame_len,
                          frame_ok, crc_err, align_err, len_err, phy_err};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Output monitor, sampled on the falling edge.
  int         n_dv = 0, n_sof = 0, n_eof = 0, n_ok = 0, n_bad = 0;
  int         sof_cyc = 0, eof_cyc = 0;
  logic [7:0] sof_byte = 8'h00;
  logic [10:0] e_len = 11'd0;
  logic [4:0] e_st = 5'd0;
  logic [7:0] cap [0:255];
  always @(negedge clk) begin
    if (data_valid) begin
      cap[n_dv % 256] = data_out;
      n_dv = n_dv + 1;
    end
    if (sof) begin
      n_sof = n_sof + 1;
      sof_byte = data_out;
      sof_cyc = cyc;
      if (!data_valid) n_bad = n_bad + 1;
    end
    if (eof) begin
      n_eof = n_eof + 1;
      eof_cyc = cyc;
      e_len = frame_len;
      e_st = {frame_ok, crc_err, align_err, len_err, phy_err};
      if (frame_ok) n_ok = n_ok + 1;
      if (data_valid) n_bad = n_bad + 1;
    end
  end

  logic [7:0]  fr [0:127];
  logic [26:0] rst_outs;
  int hi_cyc, end_cyc;
  int b_dv, b_sof, b_eof, b_ok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic [3:0] d, input logic er);
    @(posedge clk);
    #1;
    mii_rx_dv = dv;
    mii_rxd   = d;
    mii_rx_er = er;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 1'b0);
  endtask

  task automatic snap();
    b_dv = n_dv; b_sof = n_sof; b_eof = n_eof; b_ok = n_ok;
  endtask

  // Bit-serial reference CRC over fr[0..n-1].
  function automatic logic [31:0] ref_crc(input int n);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ fr[i][b];
        c = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return c;
  endfunction

  task automatic build(input int n, input bit inv);
    logic [31:0] fcs;
    for (int i = 0; i < n - 4; i++) begin
      if (i < 6)       fr[i] = 8'hFF;
      else if (i < 12) fr[i] = 8'hE0 + 8'(i - 6);
      else if (i == 12) fr[i] = 8'h08;
      else if (i == 13) fr[i] = 8'h06;
      else             fr[i] = 8'((i * 37 + 11) & 255);
    end
    fcs = ~ref_crc(n - 4);
    if (inv) fcs = ~fcs;
    for (int k = 0; k < 4; k++) fr[n - 4 + k] = fcs[8*k +: 8];
  endtask

  task automatic send_frame(input int n, input bit inv, input bit extra,
                            input int er_byte, input bit badpre, input int abort_at);
    build(n, inv);
    for (int k = 0; k < 15; k++) drive(1'b1, (badpre && k == 7) ? 4'h3 : 4'h5, 1'b0);
    drive(1'b1, 4'hD, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        @(posedge clk);
        #1 rstn = 1'b0;
        @(negedge clk);
        rst_outs = all_outs;
        drive(1'b0, 4'h0, 1'b0);
        #2 rstn = 1'b1;
        return;
      end
      drive(1'b1, fr[i][3:0], i == er_byte);
      drive(1'b1, fr[i][7:4], i == er_byte);
      if (i == 0) hi_cyc = cyc;
    end
    if (extra) drive(1'b1, 4'hA, 1'b0);
    drive(1'b0, 4'h0, 1'b0);
    end_cyc = cyc;
  endtask

  function automatic int byte_mism(input int base, input int cnt);
    int m;
    m = 0;
    for (int i = 0; i < cnt; i++) if (cap[(base + i) % 256] !== fr[i]) m++;
    return m;
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'(all_outs), 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    idle(3);
    chk("idle_outs", 32'(all_outs), 32'd0);

    // Good 64-byte frame
    snap();
    send_frame(64, 1'b0, 1'b0, -1, 1'b0, -1);
    idle(6);
    chk("good_sof_cnt", 32'(n_sof - b_sof), 32'd1);
    chk("good_sof_byte", 32'(sof_byte), 32'hFF);
    chk("good_dv_cnt", 32'(n_dv - b_dv), 32'(64 - STRIP));
    chk("good_bytes", 32'(byte_mism(b_dv, 64 - STRIP)), 32'd0);
    chk("good_sof_lat", 32'(sof_cyc - hi_cyc), 32'(1 + 2 * STRIP));
    chk("good_eof_cnt", 32'(n_eof - b_eof), 32'd1);
    chk("good_eof_lat", 32'(eof_cyc - end_cyc), 32'd1);
    chk("good_len", 32'(e_len), 32'd64);
    chk("good_status", 32'(e_st), 32'b10000);
    chk("good_hold", 32'({frame_len, frame_ok}), 32'({11'd64, 1'b1}));

    // Inverted FCS
    snap();
    send_frame(64, 1'b1, 1'b0, -1, 1'b0, -1);
    idle(6);
    chk("badfcs_dv_cnt", 32'(n_dv - b_dv), 32'(64 - STRIP));
    chk("badfcs_bytes", 32'(byte_mism(b_dv, 64 - STRIP)), 32'd0);
    chk("badfcs_eof_cnt", 32'(n_eof - b_eof), 32'd1);
    chk("badfcs_status", 32'(e_st), 32'b01000);

    // Preamble with 0x3
    snap();
    send_frame(64, 1'b0, 1'b0, -1, 1'b1, -1);
    idle(6);
    chk("badpre_sof", 32'(n_sof - b_sof), 32'd0);
    chk("badpre_dv", 32'(n_dv - b_dv), 32'd0);
    chk("badpre_eof", 32'(n_eof - b_eof), 32'd0);

    // Extra nibble
    snap();
    send_frame(64, 1'b0, 1'b1, -1, 1'b0, -1);
    idle(6);
    chk("align_dv_cnt", 32'(n_dv - b_dv), 32'(64 - STRIP));
    chk("align_len", 32'(e_len), 32'd64);
    chk("align_status", 32'(e_st), 32'b00100);

    // RX_ER during byte 20 of a 100-byte frame
    snap();
    send_frame(100, 1'b0, 1'b0, 20, 1'b0, -1);
    idle(6);
    chk("phy_len", 32'(e_len), 32'd100);
    chk("phy_status", 32'(e_st), 32'b00001);

    // Short 40-byte frame
    snap();
    send_frame(40, 1'b0, 1'b0, -1, 1'b0, -1);
    idle(6);
    chk("short_dv_cnt", 32'(n_dv - b_dv), 32'(40 - STRIP));
    chk("short_len", 32'(e_len), 32'd40);
    chk("short_status", 32'(e_st), 32'b00010);

    // Reset mid-frame, then two back-to-back good frames
    snap();
    send_frame(64, 1'b0, 1'b0, -1, 1'b0, 10);
    idle(4);
    chk("abort_rst_outs", 32'(rst_outs), 32'd0);
    chk("abort_eof", 32'(n_eof - b_eof), 32'd0);
    snap();
    send_frame(64, 1'b0, 1'b0, -1, 1'b0, -1);
    send_frame(64, 1'b0, 1'b0, -1, 1'b0, -1);
    idle(6);
    chk("b2b_eof_cnt", 32'(n_eof - b_eof), 32'd2);
    chk("b2b_ok_cnt", 32'(n_ok - b_ok), 32'd2);
    chk("b2b_dv_cnt", 32'(n_dv - b_dv), 32'(2 * (64 - STRIP)));
    chk("marker_rules", 32'(n_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
